// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Double-buffered 8-bit UART transmitter (start, 8 data LSB first,
//            parity, stop) clocked by the 16x oversampling clock mclkx16.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 1
) (
  input  logic       mclkx16,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] data,
  output logic       tx,
  output logic       txrdy,
  output logic       txbusy
);

  localparam int                 c_div_w    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(OVERSAMPLE - 1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state, w_state_n;
  logic [7:0]         r_thr, w_thr_n;
  logic               r_thr_full, w_thr_full_n;
  logic [7:0]         r_tsr, w_tsr_n;
  logic               r_par, w_par_n;
  logic [c_div_w-1:0] r_div, w_div_n;
  logic [2:0]         r_bitcnt, w_bitcnt_n;
  logic               r_tx, w_tx_n;
  logic               r_busy, w_busy_n;
  logic               w_wrap;
  logic               w_load;

  assign w_wrap = (r_div == c_div_last);
  // A write only becomes visible to the transfer check one edge later,
  // because the transfer looks at the registered full flag.
  assign w_load = r_thr_full && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_wrap));

  always_comb begin
    w_state_n    = r_state;
    w_thr_n      = r_thr;
    w_thr_full_n = r_thr_full;
    w_tsr_n      = r_tsr;
    w_par_n      = r_par;
    w_bitcnt_n   = r_bitcnt;
    w_div_n      = ((r_state == S_IDLE) || w_wrap) ? '0 : (r_div + c_div_one);
    w_tx_n       = 1'b1;

    case (r_state)
      S_IDLE: ;
      S_START: begin
        if (w_wrap) begin
          w_state_n  = S_DATA;
          w_bitcnt_n = 3'd0;
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_bitcnt == 3'd7) w_state_n  = S_PARITY;
          else                  w_bitcnt_n = r_bitcnt + 3'd1;
        end
      end
      S_PARITY: begin
        if (w_wrap) w_state_n = S_STOP;
      end
      S_STOP: begin
        if (w_wrap) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_load) begin
      w_state_n    = S_START;
      w_div_n      = '0;
      w_tsr_n      = r_thr;
      w_par_n      = (PARITY_ODD != 0) ? ~^r_thr : ^r_thr;
      w_thr_full_n = 1'b0;
    end else if (write && !r_thr_full) begin
      w_thr_n      = data;
      w_thr_full_n = 1'b1;
    end

    // Output level is decided from the next state so tx can come straight off a flop.
    case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_tsr_n[w_bitcnt_n];
      S_PARITY: w_tx_n = w_par_n;
      default:  w_tx_n = 1'b1;
    endcase

    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge mclkx16) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_thr      <= 8'h00;
      r_thr_full <= 1'b0;
      r_tsr      <= 8'h00;
      r_par      <= 1'b0;
      r_div      <= '0;
      r_bitcnt   <= 3'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_thr      <= w_thr_n;
      r_thr_full <= w_thr_full_n;
      r_tsr      <= w_tsr_n;
      r_par      <= w_par_n;
      r_div      <= w_div_n;
      r_bitcnt   <= w_bitcnt_n;
      r_tx       <= w_tx_n;
      r_busy     <= w_busy_n;
    end
  end

  assign tx     = r_tx;
  assign txrdy  = ~r_thr_full;
  assign txbusy = r_busy;

endmodule
`default_nettype wire
